// File: rtl/sticky_shift_iter_if.sv
// Handshake bundle for sticky_shift_iter: operand request channel plus result channel.
// Latency: none, wires only.
// Backpressure: in_ready gates the producer and out_ready gates the consumer.
interface sticky_shift_iter_if #(
  parameter int W  = 16,
  parameter int SW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [SW-1:0] in_shift;
  logic          in_arith;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_z;
  logic          out_busy;

  // Producer/consumer side, which drives operands and accepts results.
  modport master (
    output in_valid, in_a, in_shift, in_arith, out_ready,
    input  in_ready, out_valid, out_z, out_busy
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_a, in_shift, in_arith, out_ready,
    output in_ready, out_valid, out_z, out_busy
  );
endinterface

// File: rtl/sticky_shift_iter.sv
// Iterative right shifter with sticky collection: up to STEP places per cycle, W-bit result with sticky LSB.
// Latency: result valid ceil(min(shift,W+L)/STEP) edges after the accept edge; zero-shift results appear on the accept edge.
// Backpressure: result held until out_ready; in_ready only in IDLE (plus DONE&&out_ready when STICKY_FASTPATH_EN is defined).
module sticky_shift_iter #(
  parameter int W    = 16,
  parameter int L    = 1,
  parameter int SW   = 8,
  parameter int STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  sticky_shift_iter_if.slave bus
);

  localparam int TW = W + L;                    // working width incl. guard bits
  localparam int RW = $clog2(TW + 1);           // holds 0..TW remaining places
  localparam int CW = (SW > RW) ? SW : RW;      // compare width for clamping

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   t;
  logic [TW-1:0]   t_nxt;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   rem_nxt;
  logic            sticky_acc;
  logic            sticky_nxt;
  logic            mode;
  logic            mode_nxt;
  logic            out_valid_q;
  logic            out_valid_nxt;
  logic [W-1:0]    out_z_q;
  logic [W-1:0]    out_z_nxt;

  logic            in_ready_i;
  logic            accept;
  logic [CW-1:0]   shift_ext;
  logic [RW-1:0]   load_rem;
  logic [TW-1:0]   t_load;
  logic [RW-1:0]   k;
  logic [TW-1:0]   low_mask;
  logic            fill;
  logic [TW-1:0]   t_shifted;
  logic            step_sticky;

  // Final packing: guard bits and accumulated sticky all fold into the result LSB.
  function automatic logic [W-1:0] pack_z(input logic [TW-1:0] tv, input logic s);
    return {tv[TW-1:L+1], tv[L] | (|tv[L-1:0]) | s};
  endfunction

`ifdef STICKY_FASTPATH_EN
  // A result handoff frees the datapath on the same edge, so a new operand may load then.
  assign in_ready_i = (state == IDLE) || ((state == DONE) && bus.out_ready);
`else
  // Every handoff returns through IDLE before the next operand is taken.
  assign in_ready_i = (state == IDLE);
`endif

  assign accept = bus.in_valid && in_ready_i;

  // Shift amounts past the working width produce the same result as exactly TW places.
  assign shift_ext = CW'(bus.in_shift);
  assign load_rem  = (shift_ext >= CW'(TW)) ? RW'(TW) : RW'(shift_ext);
  assign t_load    = {bus.in_a, {L{1'b0}}};

  // One iteration: move by at most STEP places, capturing the bits that fall off.
  assign k           = (rem < RW'(STEP)) ? rem : RW'(STEP);
  assign low_mask    = ~({TW{1'b1}} << k);
  assign step_sticky = |(t & low_mask);
  assign fill        = mode & t[TW-1];
  assign t_shifted   = fill ? ~((~t) >> k) : (t >> k);

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_busy  = (state != IDLE);

  // Next-state and datapath update; an accepted operand overrides whatever the state would do.
  always_comb begin
    state_nxt     = state;
    t_nxt         = t;
    rem_nxt       = rem;
    sticky_nxt    = sticky_acc;
    mode_nxt      = mode;
    out_valid_nxt = out_valid_q;
    out_z_nxt     = out_z_q;

    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      SHIFT: begin
        t_nxt      = t_shifted;
        sticky_nxt = sticky_acc | step_sticky;
        rem_nxt    = rem - k;
        if (rem == k) begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
          out_z_nxt     = pack_z(t_shifted, sticky_acc | step_sticky);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        out_valid_nxt = 1'b0;
      end
    endcase

    if (accept) begin
      t_nxt      = t_load;
      rem_nxt    = load_rem;
      sticky_nxt = 1'b0;
      mode_nxt   = bus.in_arith;
      if (load_rem == '0) begin
        state_nxt     = DONE;
        out_valid_nxt = 1'b1;
        out_z_nxt     = pack_z(t_load, 1'b0);
      end else begin
        state_nxt     = SHIFT;
        out_valid_nxt = 1'b0;
      end
    end
  end

  // State and datapath registers; reset drops any in-flight operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      t           <= '0;
      rem         <= '0;
      sticky_acc  <= 1'b0;
      mode        <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
    end else begin
      state       <= state_nxt;
      t           <= t_nxt;
      rem         <= rem_nxt;
      sticky_acc  <= sticky_nxt;
      mode        <= mode_nxt;
      out_valid_q <= out_valid_nxt;
      out_z_q     <= out_z_nxt;
    end
  end

endmodule

// File: tb/tb_sticky_shift_iter.sv
module tb_sticky_shift_iter;
  localparam int W    = 8;
  localparam int L    = 1;
  localparam int SW   = 8;
  localparam int STEP = 2;

`ifdef STICKY_FASTPATH_EN
  localparam int B2B_GAP = 2;
`else
  localparam int B2B_GAP = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sticky_shift_iter_if #(.W(W), .SW(SW)) bus();

  sticky_shift_iter #(.W(W), .L(L), .SW(SW), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: extend, shift by the clamped amount as one arithmetic operation, fold lost bits.
  function automatic logic [W-1:0] ref_z(input logic [W-1:0] a, input logic [SW-1:0] sh, input logic ar);
    logic [63:0] v, r, lost, mask_all, z;
    int s;
    s        = (int'(sh) > W + L) ? W + L : int'(sh);
    mask_all = (64'd1 << (W + L)) - 64'd1;
    v        = {56'd0, a} << L;
    lost     = v & ((64'd1 << s) - 64'd1);
    if (ar && a[W-1]) r = (~((~v & mask_all) >> s)) & mask_all;
    else              r = v >> s;
    z = ((r >> (L + 1)) << 1) | {63'd0, ((r & ((64'd1 << (L + 1)) - 64'd1)) != 0) || (lost != 0)};
    return z[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every result transfer is compared against the oldest expected value.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got=%0h exp=none", bus.out_z);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_z !== e) begin
          failures++;
          $display("FAIL out_z got=%0h exp=%0h", bus.out_z, e);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [SW-1:0] sh, input logic ar,
                      input bit rnd_rdy, output int acc_cyc);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_shift = sh;
    bus.in_arith = ar;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=in_ready0 exp=in_ready1");
    end else begin
      exp_q.push_back(ref_z(a, sh, ar));
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_shift = SW'($urandom);
    bus.in_arith = 1'($urandom);
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Counts edges from the accept edge until out_valid is seen high.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, c0, c1;
    logic [W-1:0] ra;
    logic [SW-1:0] rs;
    logic rar;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_shift  = '0;
    bus.in_arith  = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_z",     32'(bus.out_z),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_busy",  32'(bus.out_busy),  32'd0);
    @(posedge clk); #1;

    // Logical shift by 3: two iterations, sticky from the bits shifted out.
    send(8'hB6, 8'd3, 1'b0, 1'b0, c0);
    chk("t1_busy", 32'(bus.out_busy), 32'd1);
    wait_valid(n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_z_const", 32'(bus.out_z), 32'h17);
    idle(2);

    // Clamped shifts, arithmetic then logical.
    send(8'h80, 8'd20, 1'b1, 1'b0, c0);
    wait_valid(n);
    chk("t2a_latency", 32'(n), 32'd5);
    chk("t2a_z_const", 32'(bus.out_z), 32'hFF);
    idle(2);
    send(8'h80, 8'd20, 1'b0, 1'b0, c0);
    wait_valid(n);
    chk("t2l_latency", 32'(n), 32'd5);
    chk("t2l_z_const", 32'(bus.out_z), 32'h01);
    idle(2);

    // Zero shift: result visible right after the accept edge.
    send(8'h40, 8'd0, 1'b0, 1'b0, c0);
    wait_valid(n);
    chk("t3_latency", 32'(n), 32'd0);
    chk("t3_z_const", 32'(bus.out_z), 32'h40);
    idle(2);

    // Result held while the consumer stalls.
    bus.out_ready = 1'b0;
    send(8'hB6, 8'd3, 1'b0, 1'b0, c0);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_z",     32'(bus.out_z),     32'h17);
      chk("t4_hold_rdy",   32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_after_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_after_busy",  32'(bus.out_busy),  32'd0);
    chk("t4_after_rdy",   32'(bus.in_ready),  32'd1);

    // Reset mid-shift discards the operand.
    send(8'h80, 8'd20, 1'b1, 1'b0, c0);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_z",     32'(bus.out_z),     32'd0);
    chk("t5_busy",  32'(bus.out_busy),  32'd0);
    chk("t5_rdy",   32'(bus.in_ready),  32'd1);
    send(8'hB6, 8'd3, 1'b0, 1'b0, c0);
    wait_valid(n);
    chk("t5_latency", 32'(n), 32'd2);
    idle(2);

    // Back-to-back operands; the gap depends on whether the fast handoff is built in.
    send(8'h5A, 8'd2, 1'b0, 1'b0, c0);
    send(8'hC3, 8'd2, 1'b1, 1'b0, c1);
    chk("t6_gap", 32'(c1 - c0), 32'(B2B_GAP));
    idle(4);

    // Randomized operands with a randomly stalling consumer.
    for (int i = 0; i < 150; i++) begin
      ra  = W'($urandom);
      rs  = ($urandom_range(0, 7) == 0) ? SW'($urandom) : SW'($urandom_range(0, 11));
      rar = 1'($urandom);
      send(ra, rs, rar, 1'b1, c0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
